// File: rtl/conv_unit_kxk_if.sv
// Valid/ready pixel stream bundle, one signed fixed-point sample per beat.
// Latency: none, wires only.
// Backpressure: a beat transfers when valid & ready; the source holds valid/data until then.
interface conv_unit_kxk_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/conv_unit_kxk.sv
// KxK fixed-point convolution over a raster IFM stream with bias, rounding, saturation, optional ReLU.
// Latency: 2 advancing cycles from the pixel that completes a window to its output.
// Backpressure: the whole pipeline freezes while out_valid & !out_ready; in_ready drops with it.
module conv_unit_kxk #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int IFM_SIZE    = 28,
  parameter int KERNAL_SIZE = 5,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH+$clog2(KERNAL_SIZE**2)+1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_wr_en,
  input  logic [$clog2(KERNAL_SIZE**2+1)-1:0]   w_wr_addr,
  input  logic [DATA_WIDTH-1:0]                 w_wr_data,
  input  logic                                  relu_en,
  input  logic                                  start,
  conv_unit_kxk_if.slave                        in_s,
  conv_unit_kxk_if.master                       out_s,
  output logic                                  busy,
  output logic                                  done
);
  localparam int KK     = KERNAL_SIZE*KERNAL_SIZE;
  localparam int AW     = $clog2(KK+1);
  localparam int CW     = $clog2(IFM_SIZE+1);
  localparam int PW     = 2*DATA_WIDTH;
  // One shift chain spanning K-1 full lines plus the K-1 newest pixels of the current line.
  localparam int LB_LEN = (KERNAL_SIZE-1)*IFM_SIZE + KERNAL_SIZE - 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IFM_SIZE-1);
  localparam logic [CW-1:0] EDGE_IDX = CW'(KERNAL_SIZE-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] HALF    = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_BITS-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                        state, state_nxt;
  logic                          adv, accept, in_rdy, win_ok, last_pix;
  logic [CW-1:0]                 row, col;
  logic signed [DATA_WIDTH-1:0]  weight [KK];
  logic signed [DATA_WIDTH-1:0]  bias;
  logic signed [DATA_WIDTH-1:0]  lb [LB_LEN];
  logic signed [DATA_WIDTH-1:0]  tap [KK];
  logic signed [PW-1:0]          s1_prod [KK];
  logic                          s1_vld;
  logic signed [ACC_WIDTH-1:0]   acc, rnd, shf;
  logic signed [DATA_WIDTH-1:0]  res;
  logic                          out_vld;
  logic [DATA_WIDTH-1:0]         out_dat;

  assign adv         = !out_vld || out_s.ready;
  assign accept      = in_s.valid && in_rdy;
  assign in_s.ready  = in_rdy;
  assign out_s.valid = out_vld;
  assign out_s.data  = out_dat;
  assign win_ok      = (row >= EDGE_IDX) && (col >= EDGE_IDX);
  assign last_pix    = (row == LAST_IDX) && (col == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: drain exits once stage 1 is empty and the final output is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && last_pix) state_nxt = S_DRAIN;
      S_DRAIN: if (!s1_vld && adv) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_rdy = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_RUN:   in_rdy = adv;
      S_DRAIN: in_rdy = 1'b0;
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Weight bank and bias; only writable while idle so a running frame sees a fixed kernel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < KK; i++) weight[i] <= '0;
      bias <= '0;
    end else if (state == S_IDLE && w_wr_en) begin
      for (int i = 0; i < KK; i++)
        if (w_wr_addr == AW'(i)) weight[i] <= w_wr_data;
      if (w_wr_addr == AW'(KK)) bias <= w_wr_data;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (state == S_IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == LAST_IDX) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffer chain: lb[0] is the previous pixel, lb[a-1] the pixel a steps back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LB_LEN; i++) lb[i] <= '0;
    end else if (accept) begin
      lb[0] <= in_s.data;
      for (int i = 1; i < LB_LEN; i++) lb[i] <= lb[i-1];
    end
  end

  // Window taps: incoming pixel is the bottom-right element, older ones come from the chain.
  for (genvar r = 0; r < KERNAL_SIZE; r++) begin : g_row
    for (genvar c = 0; c < KERNAL_SIZE; c++) begin : g_col
      localparam int AGE = (KERNAL_SIZE-1-r)*IFM_SIZE + (KERNAL_SIZE-1-c);
      if (AGE == 0) begin : g_new
        assign tap[r*KERNAL_SIZE+c] = in_s.data;
      end else begin : g_old
        assign tap[r*KERNAL_SIZE+c] = lb[AGE-1];
      end
    end
  end

  // Stage 1: register all KxK products for windows that land in the valid region.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      for (int i = 0; i < KK; i++) s1_prod[i] <= '0;
    end else if (adv) begin
      s1_vld <= accept && win_ok;
      if (accept)
        for (int i = 0; i < KK; i++) s1_prod[i] <= tap[i] * weight[i];
    end
  end

  // Sum, bias, round half up, saturate, optional ReLU.
  always_comb begin
    acc = '0;
    for (int i = 0; i < KK; i++)
      acc = acc + {{(ACC_WIDTH-PW){s1_prod[i][PW-1]}}, s1_prod[i]};
    rnd = acc + {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}}, bias, {FRAC_BITS{1'b0}}} + HALF;
    shf = rnd >>> FRAC_BITS;
    if (shf > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
    else if (shf < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
    else                    res = shf[DATA_WIDTH-1:0];
    if (relu_en && res[DATA_WIDTH-1]) res = '0;
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (adv) begin
      out_vld <= s1_vld;
      if (s1_vld) out_dat <= res;
    end
  end
endmodule

// File: tb/tb_conv_unit_kxk.sv
// Bench for conv_unit_kxk at IFM 6, K 3: constant-table frames, golden-model frames, stalls, resets.
// Latency: expected values queued when a window-completing pixel is accepted, popped at handshake.
// Backpressure: out_ready driven by stall requests or a random pattern; held outputs are checked.
`timescale 1ns/1ps
module tb_conv_unit_kxk;
  localparam int DW = 16, FB = 8, N = 6, K = 3, KK = 9, AW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            w_wr_en = 1'b0;
  logic [AW-1:0]   w_wr_addr = '0;
  logic [DW-1:0]   w_wr_data = '0;
  logic            relu_en = 1'b0;
  logic            start = 1'b0;
  logic            busy, done;

  conv_unit_kxk_if #(.DATA_WIDTH(DW)) in_s ();
  conv_unit_kxk_if #(.DATA_WIDTH(DW)) out_s ();

  conv_unit_kxk #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IFM_SIZE(N), .KERNAL_SIZE(K)) dut (
    .clk(clk), .reset(reset), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .relu_en(relu_en), .start(start), .in_s(in_s), .out_s(out_s), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [15:0] b;
    logic [15:0] p;
    logic        relu;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[10];

  int          total = 0, bad = 0;
  logic [15:0] pix [36];
  logic [15:0] cur_w [9];
  logic [15:0] cur_b = '0;
  int          exp_mode = 0;   // 0 constant, 1 golden model, 2 identity kernel
  logic [15:0] const_exp = '0;
  logic [15:0] sb [$];
  int          done_cnt = 0, frames = 0, stall_req = 0, stall_cycles = 0;
  bit          rand_rdy = 1'b0;
  bit          hold_pending = 1'b0;
  logic [15:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int r, input int c);
    longint acc = 0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        acc += longint'($signed(cur_w[kr*K+kc])) * longint'($signed(pix[(r-2+kr)*N + (c-2+kc)]));
    acc += longint'($signed(cur_b)) * 256;
    acc += 128;
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu_en && acc < 0) acc = 0;
    return acc[15:0];
  endfunction

  // out_ready: forced low while a stall is requested, else random or always high.
  initial begin
    out_s.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_req > 0) begin
        out_s.ready = 1'b0;
        stall_req--;
      end else begin
        out_s.ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pops, hold-under-stall checks, done pulse count.
  always @(negedge clk) begin
    if (!reset) begin
      hold_pending = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold_pending) begin
        chk("hold_valid", 32'(out_s.valid), 32'd1);
        chk("hold_data", 32'(out_s.data), 32'(held));
      end
      hold_pending = 1'b0;
      if (out_s.valid && !out_s.ready) begin
        chk("stall_in_ready", 32'(in_s.ready), 32'd0);
        hold_pending = 1'b1;
        held = out_s.data;
        stall_cycles++;
      end else if (out_s.valid && out_s.ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got %0h want no output", out_s.data);
        end else begin
          chk("out_data", 32'(out_s.data), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic load_weights();
    for (int i = 0; i < KK; i++) begin
      w_wr_en = 1'b1; w_wr_addr = AW'(i); w_wr_data = cur_w[i];
      @(posedge clk); #1;
    end
    w_wr_en = 1'b0;
  endtask

  // Bias write and start in the same idle cycle; the bias must apply to this frame.
  task automatic start_frame();
    w_wr_en = 1'b1; w_wr_addr = AW'(KK); w_wr_data = cur_b; start = 1'b1;
    @(posedge clk); #1;
    w_wr_en = 1'b0; start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_frame(input int n_pix, input bit gaps);
    int idx = 0;
    int guard = 0;
    int r, c;
    while (idx < n_pix && guard < 4000) begin
      in_s.valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_s.data  = pix[idx];
      @(negedge clk);
      if (in_s.valid && in_s.ready) begin
        r = idx / N;
        c = idx % N;
        if (r >= K-1 && c >= K-1) begin
          if (exp_mode == 0)      sb.push_back(const_exp);
          else if (exp_mode == 1) sb.push_back(model(r, c));
          else                    sb.push_back(pix[(r-1)*N + (c-1)]);
        end
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_s.valid = 1'b0;
    if (idx < n_pix) begin
      total++; bad++;
      $display("FAIL send_timeout: got %0d pixels want %0d", idx, n_pix);
    end
  endtask

  task automatic wait_done();
    int g = 0;
    frames++;
    while (done_cnt < frames && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt), 32'(frames));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic set_identity();
    for (int i = 0; i < KK; i++) cur_w[i] = 16'h0000;
    cur_w[4] = 16'h0100;
    cur_b = 16'h0000;
    for (int i = 0; i < 36; i++) pix[i] = 16'(i);
    exp_mode = 2;
  endtask

  initial begin
    vecs[0] = '{16'h0100, 16'h0000, 16'h0100, 1'b0, 16'h0900};
    vecs[1] = '{16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 16'h7FFF};
    vecs[2] = '{16'h8000, 16'h0000, 16'h7FFF, 1'b0, 16'h8000};
    vecs[3] = '{16'h8000, 16'h0000, 16'h7FFF, 1'b1, 16'h0000};
    vecs[4] = '{16'h0000, 16'h0080, 16'h1234, 1'b0, 16'h0080};
    vecs[5] = '{16'h0001, 16'h0000, 16'h0080, 1'b0, 16'h0005};
    vecs[6] = '{16'hFFFF, 16'h0000, 16'h0080, 1'b0, 16'hFFFC};
    vecs[7] = '{16'h0000, 16'hFF00, 16'h0100, 1'b0, 16'hFF00};
    vecs[8] = '{16'h0000, 16'hFF00, 16'h0100, 1'b1, 16'h0000};
    vecs[9] = '{16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0A00};

    in_s.valid = 1'b0;
    in_s.data  = '0;
    #12;
    chk("rst_in_ready", 32'(in_s.ready), 32'd0);
    chk("rst_out_valid", 32'(out_s.valid), 32'd0);
    chk("rst_out_data", 32'(out_s.data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Uniform frames with constant expected outputs.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 36; i++) pix[i] = vecs[v].p;
      for (int i = 0; i < KK; i++) cur_w[i] = vecs[v].w;
      cur_b = vecs[v].b; relu_en = vecs[v].relu;
      exp_mode = 0; const_exp = vecs[v].exp;
      load_weights();
      start_frame();
      send_frame(36, 1'b0);
      wait_done();
    end
    relu_en = 1'b0;

    // Identity kernel with a 10-cycle output stall mid-frame.
    set_identity();
    load_weights();
    start_frame();
    stall_cycles = 0;
    fork
      send_frame(36, 1'b0);
      begin
        repeat (18) @(negedge clk);
        stall_req = 10;
      end
    join
    wait_done();
    chk("stall_seen", 32'(stall_cycles >= 8), 32'd1);

    // Weight write and start during RUN must be ignored; random gaps both sides.
    rand_rdy = 1'b1;
    start_frame();
    fork
      send_frame(36, 1'b1);
      begin
        repeat (12) @(posedge clk);
        #1;
        w_wr_en = 1'b1; w_wr_addr = AW'(4); w_wr_data = 16'h7FFF; start = 1'b1;
        @(posedge clk); #1;
        w_wr_en = 1'b0; start = 1'b0;
      end
    join
    wait_done();

    // Random kernels and pixels against the golden model, with and without ReLU.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < KK; i++) cur_w[i] = 16'($urandom_range(0, 511) - 256);
      for (int i = 0; i < 36; i++) pix[i] = 16'($urandom_range(0, 1023) - 512);
      cur_b = 16'($urandom_range(0, 2047) - 1024);
      relu_en = (f == 1);
      exp_mode = 1;
      load_weights();
      start_frame();
      send_frame(36, 1'b1);
      wait_done();
    end
    relu_en = 1'b0;
    rand_rdy = 1'b0;

    // Reset for one cycle at pixel 20 of a frame.
    set_identity();
    load_weights();
    start_frame();
    send_frame(20, 1'b0);
    reset = 1'b0;
    #2;
    chk("rst_mid_out_valid", 32'(out_s.valid), 32'd0);
    chk("rst_mid_out_data", 32'(out_s.data), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_in_ready", 32'(in_s.ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;

    // Weights were cleared: a frame without reloading gives all zeros.
    exp_mode = 0; const_exp = 16'h0000; cur_b = 16'h0000;
    start_frame();
    send_frame(36, 1'b0);
    wait_done();

    // Reload and rerun the identity frame.
    set_identity();
    load_weights();
    start_frame();
    send_frame(36, 1'b0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
